// File: rtl/rpsc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpsc_pkg
// Description : Shared types and default constants for the RPSC power sequencer
// Revision    : 1.0 - initial release
// ============================================================================
package rpsc_pkg;

    localparam int c_TIMEOUT_CYC  = 256;
    localparam int c_SHUTDOWN_CYC = 64;
    localparam int c_TIMER_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AN_RAMP  = 3'd1,
        ST_G2_RAMP  = 3'd2,
        ST_DRV_RAMP = 3'd3,
        ST_RUN      = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ALARM   = 3'd1,
        FC_AN_TMO  = 3'd2,
        FC_G2_TMO  = 3'd3,
        FC_DRV_TMO = 3'd4,
        FC_LOST_OK = 3'd5
    } fault_code_t;

endpackage
`default_nettype wire

// File: rtl/rpsc_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : rpsc_seq_timer
// Description : Per-step cycle timer, clearable, saturating, terminal compare
// Revision    : 1.0 - initial release
// ============================================================================
module rpsc_seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count != {WIDTH{1'b1}}) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_term = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/rpsc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rpsc_sequencer
// Description : Anode / G2 / driver supply ramp sequencer with fault latching
// Revision    : 1.0 - initial release
// ============================================================================
module rpsc_sequencer
    import rpsc_pkg::*;
#(
    parameter int TIMEOUT_CYC  = c_TIMEOUT_CYC,
    parameter int SHUTDOWN_CYC = c_SHUTDOWN_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       fault_ack,
    input  logic       not_alarm,
    input  logic       drv_not_alarm,
    input  logic       ground_hold_ok,
    input  logic       not_g2_ok,
    input  logic       not_dr_amp_ok,
    output logic       an_ps_on,
    output logic       g2_ps_on,
    output logic       dr_amp_on,
    output logic       ready,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] seq_state
);

    localparam logic [c_TIMER_W-1:0] c_TMO_TERM = c_TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_SD_TERM  = c_TIMER_W'(SHUTDOWN_CYC - 1);

    state_t                r_state;
    state_t                w_next;
    fault_code_t           r_code;
    fault_code_t           w_code;
    logic                  w_alarm;
    logic                  w_lost;
    logic                  w_term;
    logic                  w_clear;
    logic [c_TIMER_W-1:0]  w_term_val;

    assign w_alarm    = !(not_alarm && drv_not_alarm);
    assign w_lost     = !ground_hold_ok || not_g2_ok || not_dr_amp_ok;
    assign w_clear    = (w_next != r_state);
    assign w_term_val = (r_state == ST_SHUTDOWN) ? c_SD_TERM : c_TMO_TERM;

    rpsc_seq_timer #(
        .WIDTH (c_TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_clear),
        .i_term  (w_term_val),
        .o_term  (w_term)
    );

    // Branch order inside each state encodes the priority:
    // alarm, then timeout / lost-OK, then stop, then step progress.
    always_comb begin
        w_next = r_state;
        w_code = FC_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start_req && !stop_req && !w_alarm) w_next = ST_AN_RAMP;
            end
            ST_AN_RAMP: begin
                if (w_alarm)             begin w_next = ST_FAULT; w_code = FC_ALARM;  end
                else if (w_term)         begin w_next = ST_FAULT; w_code = FC_AN_TMO; end
                else if (stop_req)       w_next = ST_SHUTDOWN;
                else if (ground_hold_ok) w_next = ST_G2_RAMP;
            end
            ST_G2_RAMP: begin
                if (w_alarm)             begin w_next = ST_FAULT; w_code = FC_ALARM;  end
                else if (w_term)         begin w_next = ST_FAULT; w_code = FC_G2_TMO; end
                else if (stop_req)       w_next = ST_SHUTDOWN;
                else if (!not_g2_ok)     w_next = ST_DRV_RAMP;
            end
            ST_DRV_RAMP: begin
                if (w_alarm)             begin w_next = ST_FAULT; w_code = FC_ALARM;   end
                else if (w_term)         begin w_next = ST_FAULT; w_code = FC_DRV_TMO; end
                else if (stop_req)       w_next = ST_SHUTDOWN;
                else if (!not_dr_amp_ok) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_alarm)             begin w_next = ST_FAULT; w_code = FC_ALARM;   end
                else if (w_lost)         begin w_next = ST_FAULT; w_code = FC_LOST_OK; end
                else if (stop_req)       w_next = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (w_alarm)             begin w_next = ST_FAULT; w_code = FC_ALARM; end
                else if (w_term)         w_next = ST_IDLE;
            end
            ST_FAULT: begin
                w_code = r_code;
                if (fault_ack && !w_alarm) begin
                    w_next = ST_IDLE;
                    w_code = FC_NONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Enables are registered from the next state so they always match seq_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_code    <= FC_NONE;
            an_ps_on  <= 1'b0;
            g2_ps_on  <= 1'b0;
            dr_amp_on <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_code    <= w_code;
            an_ps_on  <= (w_next inside {ST_AN_RAMP, ST_G2_RAMP, ST_DRV_RAMP, ST_RUN, ST_SHUTDOWN});
            g2_ps_on  <= (w_next inside {ST_G2_RAMP, ST_DRV_RAMP, ST_RUN});
            dr_amp_on <= (w_next inside {ST_DRV_RAMP, ST_RUN});
            ready     <= (w_next == ST_RUN);
            fault     <= (w_next == ST_FAULT);
        end
    end

    assign seq_state  = r_state;
    assign fault_code = r_code;

endmodule
`default_nettype wire
